// File: rtl/rx_interface_if.sv
// Receive-side bundle: serial line in, assembled word and status strobes out.
interface rx_interface_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                     rx;
  logic [2*DATA_BITS-1:0]   data_out;
  logic                     rx_valid;
  logic                     frame_err;
  logic                     busy;

  modport master (
    output rx,
    input  data_out,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output data_out,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/rx_interface.sv
// 8N1 UART receiver with 16x oversampling that pairs bytes (low first) into one word
// and reports it with a single-cycle valid strobe.
module rx_interface #(
  parameter int unsigned BAUD_DIV  = 163,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rx_interface_if.slave      bus
);

  localparam int unsigned TickW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned NW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic                   rx_meta_q, rx_s_q;
  logic [TickW-1:0]       tick_cnt_q;
  logic                   tick;

  state_e                 state_q, state_d;
  logic [3:0]             s_q, s_d;
  logic [NW-1:0]          n_q, n_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   lo_q, lo_d;
  logic                   sel_q, sel_d;
  logic [2*DATA_BITS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  // Synchronizer presets high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick; deliberately not restarted on a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  assign tick = (tick_cnt_q == TickW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      lo_q    <= '0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      lo_q    <= lo_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    lo_d    = lo_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        s_d = '0;
        // Start edge is checked every clock, not just on ticks.
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (tick) begin
          if (s_q == 4'd7) begin
            s_d = '0;
            if (!rx_s_q) begin
              state_d = StData;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (n_q == NW'(DATA_BITS - 1)) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            state_d = StIdle;
            s_d     = '0;
            if (rx_s_q) begin
              if (!sel_q) begin
                lo_d  = shreg_q;
                sel_d = 1'b1;
              end else begin
                data_d  = {shreg_q, lo_q};
                valid_d = 1'b1;
                sel_d   = 1'b0;
              end
            end else begin
              // Bad stop bit: drop this byte and any pending low byte to resync pairing.
              ferr_d = 1'b1;
              sel_d  = 1'b0;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
        s_d     = '0;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != StIdle);

endmodule
